// File: rtl/sram_bus_pkg.sv
// ---------------------------------------------------------------------------
// sram_bus_pkg
//   Shared types and constants for the two-master SRAM request arbiter.
//   Provides the request payload struct, the arbiter FSM state encoding,
//   the master count and a small helper that classifies a request as a read.
//
//   The struct field widths are the package widths below; the arbiter's
//   ADDR_WIDTH / DATA_WIDTH parameters default to these and must be kept
//   equal to them if overridden.
// ---------------------------------------------------------------------------
package sram_bus_pkg;

  localparam int unsigned SRAM_NUM_MASTERS = 2;
  localparam int unsigned SRAM_ADDR_W      = 32;
  localparam int unsigned SRAM_DATA_W      = 32;
  localparam int unsigned SRAM_BM_W        = SRAM_DATA_W / 8;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_BM_W-1:0]   wmask;
  } sram_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } sram_arb_state_t;

  // An all-zero byte mask marks a read.
  function automatic logic sram_is_read(input sram_req_t req);
    return (req.wmask == '0);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// ---------------------------------------------------------------------------
// sram_arb_pick
//   Two-way grant selection for the SRAM arbiter.
//   Build option SRAM_ARB_RR_EN:
//     defined   - round robin; a one-bit pointer names the master that has
//                 priority and moves past the winner on every granted
//                 handshake (advance=1).
//     undefined - fixed priority, m1 over m0; no state, so no clock/reset
//                 or advance ports exist in this build.
//
// Ports
//   clk        in   clock (round-robin build only)
//   rst        in   synchronous active-low reset (round-robin build only)
//   advance    in   a grant from this cycle was accepted (round-robin only)
//   req_valid  in   per-master request valid
//   grant      out  one-hot grant, all zero when nobody requests
// ---------------------------------------------------------------------------
module sram_arb_pick
  import sram_bus_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
`endif
  input  logic [SRAM_NUM_MASTERS-1:0] req_valid,
  output logic [SRAM_NUM_MASTERS-1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  // ptr_q = index of the master that currently has priority
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = '0;
    if (ptr_q == 1'b0) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end else begin
      if (req_valid[1])      grant = 2'b10;
      else if (req_valid[0]) grant = 2'b01;
    end
  end

  // Priority passes to the master that did not just win.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~grant[1];
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = '0;
    if (req_valid[1])      grant = 2'b10;
    else if (req_valid[0]) grant = 2'b01;
  end
`endif

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//   Two-master request arbiter and read-response router placed directly in
//   front of a single-port SRAM with registered read data.
//   m0 = instruction fetch, m1 = load/store unit.
//   One request is granted per cycle; only one read is ever outstanding, so
//   responses come back in issue order. A read handshaken at cycle T shows
//   resp_valid at T+1; while that response is stalled no new SRAM access is
//   issued, keeping sram_rdata stable. Accepting a response lets the next
//   request issue in the same cycle (one read per cycle sustained).
//
//   Build option SRAM_ARB_RR_EN selects round-robin arbitration
//   (default: fixed priority m1 > m0), see sram_arb_pick.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active low
//   mN_req_valid   in   request valid                       (N = 0,1)
//   mN_req_ready   out  request accepted this cycle
//   mN_req_addr    in   byte address
//   mN_req_wdata   in   write data
//   mN_req_wmask   in   byte write mask, 0 = read
//   mN_resp_valid  out  read data valid
//   mN_resp_ready  in   master accepts read data
//   mN_resp_rdata  out  read data
//   sram_en        out  SRAM access strobe
//   sram_wmask     out  zero-extended byte mask, 0 = read
//   sram_addr      out  SRAM address
//   sram_wdata     out  SRAM write data
//   sram_rdata     in   SRAM registered read data
//
// FSM states
//   state    | meaning
//   ST_IDLE  | nothing pending, a request may issue
//   ST_RESP  | read data pending for owner_q; issue only when it is accepted
// ---------------------------------------------------------------------------
module sram_req_arbiter
  import sram_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
  parameter int unsigned WM_W       = $clog2(DATA_WIDTH),
  localparam int unsigned BM_W      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic [BM_W-1:0]       m0_req_wmask,
  output logic                  m0_resp_valid,
  input  logic                  m0_resp_ready,
  output logic [DATA_WIDTH-1:0] m0_resp_rdata,

  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  input  logic [BM_W-1:0]       m1_req_wmask,
  output logic                  m1_resp_valid,
  input  logic                  m1_resp_ready,
  output logic [DATA_WIDTH-1:0] m1_resp_rdata,

  output logic                  sram_en,
  output logic [WM_W-1:0]       sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  sram_arb_state_t state_q, state_d;
  logic            owner_q, owner_d;

  sram_req_t                   req [SRAM_NUM_MASTERS];
  sram_req_t                   win_req;
  logic [SRAM_NUM_MASTERS-1:0] req_valid;
  logic [SRAM_NUM_MASTERS-1:0] req_ready;
  logic [SRAM_NUM_MASTERS-1:0] resp_valid;
  logic [SRAM_NUM_MASTERS-1:0] resp_ready;
  logic [SRAM_NUM_MASTERS-1:0] grant;
  logic                        win_idx;
  logic                        resp_done;
  logic                        issue_ok;
  logic                        fire;

  assign req[0].addr  = m0_req_addr;
  assign req[0].wdata = m0_req_wdata;
  assign req[0].wmask = m0_req_wmask;
  assign req[1].addr  = m1_req_addr;
  assign req[1].wdata = m1_req_wdata;
  assign req[1].wmask = m1_req_wmask;

  assign req_valid  = {m1_req_valid, m0_req_valid};
  assign resp_ready = {m1_resp_ready, m0_resp_ready};

  sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
    .advance   (fire),
`endif
    .req_valid (req_valid),
    .grant     (grant)
  );

  // Outputs are forced quiet while rst is low, so a read caught in flight
  // by reset never shows a response, even in the cycle reset is asserted.
  always_comb begin
    resp_valid = '0;
    if (rst && (state_q == ST_RESP)) resp_valid[owner_q] = 1'b1;
  end

  assign resp_done = |(resp_valid & resp_ready);
  assign issue_ok  = rst && ((state_q == ST_IDLE) || resp_done);
  assign req_ready = issue_ok ? grant : '0;
  // grant is only ever set for a valid master, so ready alone means handshake
  assign fire      = |req_ready;
  assign win_idx   = grant[1];
  assign win_req   = req[win_idx];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (fire) begin
      if (sram_is_read(win_req)) begin
        state_d = ST_RESP;
        owner_d = win_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (resp_done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign sram_en    = fire;
  assign sram_addr  = win_req.addr;
  assign sram_wdata = win_req.wdata;
  // Mask is only meaningful with en; keep it zero otherwise.
  assign sram_wmask = fire ? WM_W'(win_req.wmask) : '0;

  assign m0_req_ready  = req_ready[0];
  assign m1_req_ready  = req_ready[1];
  assign m0_resp_valid = resp_valid[0];
  assign m1_resp_valid = resp_valid[1];
  assign m0_resp_rdata = resp_valid[0] ? sram_rdata : '0;
  assign m1_resp_rdata = resp_valid[1] ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;
  import sram_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic [31:0] m0_req_addr = '0, m1_req_addr = '0;
  logic [31:0] m0_req_wdata = '0, m1_req_wdata = '0;
  logic [3:0]  m0_req_wmask = '0, m1_req_wmask = '0;
  logic        m0_resp_ready = 1'b1, m1_resp_ready = 1'b1;
  logic        m0_req_ready, m1_req_ready;
  logic        m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_resp_rdata, m1_resp_rdata;
  logic        sram_en;
  logic [4:0]  sram_wmask;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;

  sram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask), .m0_resp_valid(m0_resp_valid),
    .m0_resp_ready(m0_resp_ready), .m0_resp_rdata(m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask), .m1_resp_valid(m1_resp_valid),
    .m1_resp_ready(m1_resp_ready), .m1_resp_rdata(m1_resp_rdata),
    .sram_en(sram_en), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // ---------------- SRAM model: registered read, byte-masked write ----------
  logic        mem_clr = 1'b1;
  logic [31:0] wr_mem [0:1023];
  logic        wr_vld [0:1023];

  function automatic logic [31:0] preload(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h1111_0100;
      32'h0000_0104: return 32'h2222_0104;
      32'h0000_0200: return 32'h0000_0000;
      default:       return 32'h5A5A_0000 ^ a;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return wr_vld[a[11:2]] ? wr_mem[a[11:2]] : preload(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [4:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) wr_vld[i] <= 1'b0;
      sram_rdata <= '0;
    end else if (sram_en) begin
      if (sram_wmask == '0) sram_rdata <= mem_rd(sram_addr);
      else begin
        wr_mem[sram_addr[11:2]] <= merge(mem_rd(sram_addr), sram_wdata, sram_wmask);
        wr_vld[sram_addr[11:2]] <= 1'b1;
      end
    end
  end

  // ---------------- bookkeeping ---------------------------------------------
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { int m; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   resp_cyc_q[$];
  int   hs_q[$];

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) fail(name, act, req);
    else checks++;
  endtask

  task automatic push_exp(input int m, input logic [31:0] d);
    exp_t e;
    e.m = m;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // ---------------- response monitor / scoreboard ---------------------------
  always @(negedge clk) begin : mon
    exp_t e;
    if (m0_resp_valid && m1_resp_valid) fail("resp_both_valid", 32'h3, 32'h1);
    for (int m = 0; m < 2; m++) begin
      if ((m == 0) ? (m0_resp_valid && m0_resp_ready) : (m1_resp_valid && m1_resp_ready)) begin
        resp_cyc_q.push_back(cycle);
        if (exp_q.size() == 0) fail("unexpected_resp_master", m, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("resp_master", m, e.m);
          chk("resp_data", (m == 0) ? m0_resp_rdata : m1_resp_rdata, e.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  function automatic logic get_ready(input int m);
    return (m == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm);
    if (m == 0) begin
      m0_req_valid = v; m0_req_addr = a; m0_req_wdata = wd; m0_req_wmask = wm;
    end else begin
      m1_req_valid = v; m1_req_addr = a; m1_req_wdata = wd; m1_req_wmask = wm;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the handshake cycle (or after the budget).
  task automatic wait_hs(input int m, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_ready(m)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic drv_stream(input int m, input logic [31:0] base, input int n, input bit push);
    bit ok;
    for (int i = 0; i < n; i++) begin
      drive(m, 1'b1, base + 32'(4 * i), '0, '0);
      wait_hs(m, "stream_hs", ok);
      if (ok) begin
        hs_q.push_back(cycle);
        if (push) push_exp(m, 32'h5A5A_0000 ^ (base + 32'(4 * i)));
      end
      step();
    end
    drive(m, 1'b0, '0, '0, '0);
  endtask

  function automatic int span(input int q[$]);
    int lo, hi;
    lo = q[0];
    hi = q[0];
    foreach (q[i]) begin
      if (q[i] < lo) lo = q[i];
      if (q[i] > hi) hi = q[i];
    end
    return hi - lo;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=0x%08h required=0x%08h", cycle, 0);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ---------------------------------------
  initial begin
    bit ok;
    // Reset: a pending request must not be accepted.
    rst = 1'b0;
    drive(0, 1'b1, 32'h0, '0, '0);
    step();
    mem_clr = 1'b0;
    step();
    @(negedge clk);
    chk("rst_m0_req_ready", m0_req_ready, 0);
    chk("rst_m1_req_ready", m1_req_ready, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_m0_resp_valid", m0_resp_valid, 0);
    chk("rst_m1_resp_valid", m1_resp_valid, 0);
    step();
    drive(0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    step();

    // 1. Reset in the cycle after a read issue drops the read.
    drive(0, 1'b1, 32'h100, '0, '0);
    wait_hs(0, "t1_hs", ok);
    step();
    drive(0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rst_m0_resp_valid", m0_resp_valid, 0);
    chk("t1_rst_sram_en", sram_en, 0);
    step();
    step();
    rst = 1'b1;
    drive(0, 1'b1, 32'h104, '0, '0);
    @(negedge clk);
    chk("t1_idle_m0_req_ready", m0_req_ready, 1);
    if (m0_req_ready) push_exp(0, 32'h2222_0104);
    step();
    drive(0, 1'b0, '0, '0, '0);
    step();
    step();

    // 2. Single read with T+1 latency.
    drive(0, 1'b1, 32'h8000_0000, '0, '0);
    wait_hs(0, "t2_hs", ok);
    chk("t2_sram_en", sram_en, 1);
    chk("t2_sram_wmask", sram_wmask, 0);
    chk("t2_sram_addr", sram_addr, 32'h8000_0000);
    push_exp(0, 32'hDEAD_BEEF);
    step();
    drive(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("t2_m0_resp_valid_t1", m0_resp_valid, 1);
    chk("t2_m0_resp_rdata_t1", m0_resp_rdata, 32'hDEAD_BEEF);
    step();
    step();

    // 3. Masked write from m1, then read back.
    drive(1, 1'b1, 32'h200, 32'h1122_3344, 4'b0011);
    wait_hs(1, "t3_wr_hs", ok);
    chk("t3_wr_sram_en", sram_en, 1);
    chk("t3_wr_sram_wmask", sram_wmask, 5'b00011);
    chk("t3_wr_sram_wdata", sram_wdata, 32'h1122_3344);
    step();
    drive(1, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("t3_no_write_resp", m1_resp_valid, 0);
    step();
    drive(1, 1'b1, 32'h200, '0, '0);
    wait_hs(1, "t3_rd_hs", ok);
    push_exp(1, 32'h0000_3344);
    step();
    drive(1, 1'b0, '0, '0, '0);
    step();
    step();

    // 4. Response backpressure on m1 while m0 waits.
    m1_resp_ready = 1'b0;
    drive(1, 1'b1, 32'h200, '0, '0);
    wait_hs(1, "t4_hs", ok);
    push_exp(1, 32'h0000_3344);
    step();
    drive(1, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 32'h104, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_m1_resp_valid_hold", m1_resp_valid, 1);
      chk("t4_m1_resp_rdata_hold", m1_resp_rdata, 32'h0000_3344);
      chk("t4_m0_req_ready_blocked", m0_req_ready, 0);
      chk("t4_sram_en_blocked", sram_en, 0);
      step();
    end
    m1_resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_m0_granted_on_accept", m0_req_ready, 1);
    chk("t4_sram_en_on_accept", sram_en, 1);
    if (m0_req_ready) push_exp(0, 32'h2222_0104);
    step();
    drive(0, 1'b0, '0, '0, '0);
    step();
    step();

    // Reset to bring the round-robin pointer back to m0.
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();

    // 5. Contention: both masters stream 4 reads.
`ifdef SRAM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 32'h5A5A_0000 ^ (32'h300 + 32'(4 * i)));
      push_exp(1, 32'h5A5A_0000 ^ (32'h400 + 32'(4 * i)));
    end
`else
    for (int i = 0; i < 4; i++) push_exp(1, 32'h5A5A_0000 ^ (32'h400 + 32'(4 * i)));
    for (int i = 0; i < 4; i++) push_exp(0, 32'h5A5A_0000 ^ (32'h300 + 32'(4 * i)));
`endif
    hs_q.delete();
    fork
      drv_stream(0, 32'h300, 4, 1'b0);
      drv_stream(1, 32'h400, 4, 1'b0);
    join
    step();
    step();
    chk("t5_grant_count", hs_q.size(), 8);
    if (hs_q.size() == 8) chk("t5_grant_span", span(hs_q), 7);

    // 6. Back-to-back: 8 reads from m0, one response per cycle.
    resp_cyc_q.delete();
    hs_q.delete();
    drv_stream(0, 32'h500, 8, 1'b1);
    step();
    step();
    chk("t6_resp_count", resp_cyc_q.size(), 8);
    if (resp_cyc_q.size() == 8) chk("t6_resp_span", span(resp_cyc_q), 7);

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
